// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment vector type, hex glyph table and blank code.
// Segment order is {g,f,e,d,c,b,a}, active-high, bit0 = a.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment glyph decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed DIGITS-wide hex display driver with guard blanking, frame-synchronous
// value swap, leading-zero suppression and selectable output polarity.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 2,
    parameter bit SEG_ACT_LO = 1'b0,
    parameter bit AN_ACT_LO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  load_i,
    input  logic                  lzs_en_i,
    output seg_t                  seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIGITS-1:0] AN_INACT  = {DIGITS{AN_ACT_LO}};
    localparam seg_t              SEG_INACT = {7{SEG_ACT_LO}};

    generate
        if (DIGITS < 1) begin : g_bad_digits
            $error("seven_seg_scan: DIGITS must be >= 1");
        end
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("seven_seg_scan: SCAN_DIV must be >= 2");
        end
        if (GUARD >= SCAN_DIV) begin : g_bad_guard
            $error("seven_seg_scan: GUARD must be < SCAN_DIV");
        end
    endgenerate

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                slot_end;
    logic                boundary;

    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] active_val;
    logic [DIGITS-1:0]   active_dp;
    logic                pending;

    logic [DIGITS-1:0]   supp;
    logic [3:0]          nib_p0;
    seg_t                lut_seg_p0;
    logic                in_guard_p0;
    logic [DIGITS-1:0]   onehot_p0;
    logic [DIGITS-1:0]   an_p0;
    seg_t                seg_p0;
    logic                dp_p0;

    assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    assign boundary = slot_end && (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Loads land in the shadow; the displayed copy only changes at a frame boundary,
    // and a load coinciding with the boundary stays pending for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load_i) begin
                shadow_val <= value_i;
                shadow_dp  <= dp_i;
            end
            if (boundary && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            if (load_i) begin
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        supp     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (active_val[4*k +: 4] == 4'h0);
            if (k > 0) begin
                supp[k] = lzs_en_i && zero_run;
            end
        end
    end

    // ---- stage p0: decode current slot (active-high) ----
    assign nib_p0      = active_val[4*int'(idx) +: 4];
    assign in_guard_p0 = (cnt < CNT_W'(GUARD));
    assign onehot_p0   = DIGITS'(1) << idx;

    hex_to_seg u_hex_to_seg (
        .nibble (nib_p0),
        .seg    (lut_seg_p0)
    );

    always_comb begin
        an_p0  = '0;
        seg_p0 = SEG_OFF;
        dp_p0  = 1'b0;
        if (!in_guard_p0) begin
            if (supp[idx]) begin
                // Suppressed digit still lights its decimal point if requested.
                if (active_dp[idx]) begin
                    an_p0 = onehot_p0;
                    dp_p0 = 1'b1;
                end
            end else begin
                an_p0  = onehot_p0;
                seg_p0 = lut_seg_p0;
                dp_p0  = active_dp[idx];
            end
        end
    end

    // ---- stage p1: registered pins with polarity applied ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o    <= AN_INACT;
            seg_o   <= SEG_INACT;
            dp_o    <= SEG_ACT_LO;
            frame_o <= 1'b0;
        end else begin
            an_o    <= an_p0 ^ AN_INACT;
            seg_o   <= seg_p0 ^ SEG_INACT;
            dp_o    <= dp_p0 ^ SEG_ACT_LO;
            frame_o <= boundary;
        end
    end

endmodule
